hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage summer CPU. It sits beside the register-forwarding unit and drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It handles load-use stalls, which forwarding cannot cover, and control-flow flushes. It also freezes the pipeline while a fixed-latency multiply/divide instruction occupies EX.

## Interface
- MD_LATENCY, 4, cycles a mul/div instruction occupies EX; legal range ≥ 2
- STAT_W, 32, width of statistics counters (used only with HAZARD_STATS_EN)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID
- ID_UsesRt  in  1  the ID instruction reads rt as an operand
- ID_Jump  in  1  j/jal/jr/jalr resolved in ID
- EX_rd  in  5  destination of the EX instruction
- EX_MemRead  in  1  the EX instruction is a load (MemToReg == 2'b01)
- EX_BranchTaken  in  1  branch in EX resolved taken
- EX_MulDiv  in  1  the EX instruction is mul/div
- PC_Write  out  1  PC load enable
- IFID_Write, IFID_Flush  out  1 each
- IDEX_Write, IDEX_Flush  out  1 each  (flush inserts a bubble)
- EXMEM_Flush  out  1  bubble into MEM while EX is frozen
- MD_Busy  out  1  mul/div stall active
- MD_Done  out  1  mul/div result valid this cycle; EX advances
- Stall_Cnt, Flush_Cnt  out  STAT_W each  (only with HAZARD_STATS_EN)

## Operation
- Load-use hazard (LU) = EX_MemRead && EX_rd != 0 && (EX_rd == ID_rs || (ID_UsesRt && EX_rd == ID_rt)).
- FSM has two states.
  - RUN is the reset state.
  - MD_WAIT holds a down-counter cnt of width clog2(MD_LATENCY), reset 0.
- RUN, with EX_MulDiv = 1:
  - PC_Write = IFID_Write = IDEX_Write = 0, EXMEM_Flush = 1, MD_Busy = 1.
  - cnt <= MD_LATENCY-2; go to MD_WAIT.
- MD_WAIT, with cnt != 0: same outputs as the RUN entry cycle; cnt decrements.
- MD_WAIT, with cnt == 0:
  - MD_Done = 1, MD_Busy = 0; go to RUN.
  - All other outputs are evaluated as in RUN without the mul/div term.
- RUN without mul/div uses the following priority; all unlisted controls are Write = 1 and Flush = 0.
  1. EX_BranchTaken: IFID_Flush = 1, IDEX_Flush = 1, PC_Write = 1. Any LU or ID_Jump is on the wrong path and is ignored.
  2. LU: PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1. A jump in ID waits, so IFID_Flush = 0.
  3. ID_Jump: IFID_Flush = 1.
- The mul/div instruction occupies EX for exactly MD_LATENCY cycles, with MD_LATENCY-1 stall cycles.
- EX_MulDiv stays high during MD_WAIT. It is ignored until the FSM returns to RUN. A back-to-back mul/div then restarts the sequence.
- EX_BranchTaken and EX_MulDiv are mutually exclusive by decode. If both are high, mul/div wins.

## Timing
- All outputs are combinational from the inputs and the registered state/cnt. There is no output register, so decisions take effect in the same cycle.
- The FSM, cnt and counters update on the rising clk edge.
- While reset = 1:
  - PC_Write = IFID_Write = IDEX_Write = 1.
  - All flushes = 0; MD_Busy = MD_Done = 0.
  - On the edge: state <= RUN, cnt <= 0, Stall_Cnt = Flush_Cnt <= 0.
- Reset in MD_WAIT aborts the sequence. The first cycle after reset is RUN.
- An LU stall lasts exactly one cycle: the bubble removes the load from EX.

## Configuration
- HAZARD_STATS_EN defined:
  - Stall_Cnt increments on every cycle with PC_Write = 0.
  - Flush_Cnt increments on every cycle with IFID_Flush = 1.
  - Both counters wrap at 2^STAT_W and clear on reset.
- Not defined: the counters and ports are absent and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the state encoding (HZ_RUN = 1'b0, HZ_MD_WAIT = 1'b1);
  - the MemToReg load code 2'b01;
  - the register-zero constant.
- One natural sub-module, hazard_md_seq, contains the MD FSM and counter and outputs MD_Busy and MD_Done. Priority logic lives in the top level.

## Test plan
- EX_MemRead = 1, EX_rd = 8, ID_rs = 8 → one cycle of PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1. Next cycle (EX_MemRead = 0) all controls are nominal.
- EX_MemRead = 1, EX_rd = 0, ID_rs = 0 → no stall. EX_rd = 9, ID_rt = 9, ID_UsesRt = 0 → no stall.
- EX_BranchTaken = 1 together with LU and ID_Jump → PC_Write = 1, IFID_Flush = 1, IDEX_Flush = 1, Stall_Cnt unchanged.
- ID_Jump = 1 with LU on ID_rs → cycle 1 stall with IFID_Flush = 0; cycle 2 IFID_Flush = 1.
- MD_LATENCY = 4, EX_MulDiv held 4 cycles → MD_Busy = 1 and EXMEM_Flush = 1 for cycles 1-3, MD_Done = 1 in cycle 4. Repeat with MD_LATENCY = 2 → one stall cycle.
- Reset asserted in the second MD_WAIT cycle → next cycle PC_Write = 1, MD_Busy = 0, counters = 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: the state encoding
//   of the mul/div sequencer, the MemToReg code that marks a load, and the
//   register-zero constant used to suppress hazards on $zero.
package hazard_ctrl_pkg;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/hazard_md_seq.sv
// hazard_md_seq
//   Multiply/divide sequencer. Holds the EX stage frozen for MD_LATENCY-1
//   cycles after a mul/div enters EX, then raises md_done for one cycle.
//   Ports:
//     clk, reset  - pipeline clock, synchronous active-high reset
//     md_req      - mul/div instruction present in EX (ignored in MD_WAIT)
//     md_busy     - stall cycle in progress
//     md_done     - result valid this cycle; EX advances
module hazard_md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_req,
  output logic md_busy,
  output logic md_done
);

  localparam int unsigned    CNT_W    = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  hz_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are suppressed while reset is high so the pipeline sees nominal
  // controls even if reset lands in the middle of a sequence.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    if (!reset) begin
      case (state)
        HZ_RUN: begin
          if (md_req) begin
            md_busy  = 1'b1;
            cnt_nx   = CNT_LOAD;
            state_nx = HZ_MD_WAIT;
          end
        end
        HZ_MD_WAIT: begin
          if (cnt != '0) begin
            md_busy = 1'b1;
            cnt_nx  = cnt - CNT_W'(1);
          end else begin
            md_done  = 1'b1;
            state_nx = HZ_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and sequencing controller for the five-stage CPU.
//   Drives PC / IF/ID / ID/EX write enables and flushes for load-use stalls,
//   taken branches, jumps and fixed-latency mul/div freezes.
//   Ports:
//     clk, reset                 - clock, synchronous active-high reset
//     ID_rs, ID_rt, ID_UsesRt    - operands of the instruction in ID
//     ID_Jump                    - jump resolved in ID
//     EX_rd, EX_MemRead          - destination / load flag of EX instruction
//     EX_BranchTaken, EX_MulDiv  - branch taken / mul-div in EX
//     PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush
//     MD_Busy, MD_Done           - mul/div stall / completion
//     Stall_Cnt, Flush_Cnt       - statistics, present only with
//                                  HAZARD_STATS_EN defined
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned STAT_W     = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Jump,
  input  logic [4:0] EX_rd,
  input  logic       EX_MemRead,
  input  logic       EX_BranchTaken,
  input  logic       EX_MulDiv,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       MD_Busy,
  output logic       MD_Done
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] Stall_Cnt,
  output logic [STAT_W-1:0] Flush_Cnt
`endif
);

  logic load_use;

  assign load_use = EX_MemRead && (EX_rd != REG_ZERO) &&
                    ((EX_rd == ID_rs) || (ID_UsesRt && (EX_rd == ID_rt)));

  hazard_md_seq #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_seq (
    .clk    (clk),
    .reset  (reset),
    .md_req (EX_MulDiv),
    .md_busy(MD_Busy),
    .md_done(MD_Done)
  );

  // The done cycle falls through to the normal priority chain: the mul/div
  // term is carried entirely by MD_Busy.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (!reset) begin
      if (MD_Busy) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Flush = 1'b1;
      end else if (EX_BranchTaken) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (load_use) begin
        // A jump in ID waits out the stall; it is flushed next cycle.
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end else if (ID_Jump) begin
        IFID_Flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (!PC_Write)  Stall_Cnt <= Stall_Cnt + STAT_W'(1);
      if (IFID_Flush) Flush_Cnt <= Flush_Cnt + STAT_W'(1);
    end
  end
`endif

endmodule
